// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO for ALU results.
// Each entry holds {result, operation tag, overflow flag, error flag}.
// Alongside the queue the block keeps two accumulated statistics:
// a sticky overflow flag and a saturating error counter.
// Both are cleared by i_CLR_STAT, but a set arriving in the same cycle wins.
//
// Handshake rules, upstream and downstream alike:
// - A transfer happens on a rising edge where valid and ready are both 1.
// - valid never depends combinationally on ready, and ready never on valid.
// - o_READY depends only on occupancy and reset, so a full FIFO refuses a
//   push even in a cycle where the head is being popped.
module alu_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    // upstream (ALU side)
    input  logic                       i_VALID,
    output logic                       o_READY,
    input  logic [WIDTH-1:0]           i_Y,
    input  logic [1:0]                 i_SEL,
    input  logic                       i_OVF,
    input  logic                       i_ERR,
    // downstream (consumer side)
    output logic                       o_VALID,
    input  logic                       i_READY,
    output logic [WIDTH-1:0]           o_Y,
    output logic [1:0]                 o_SEL,
    output logic                       o_OVF,
    output logic                       o_ERR,
    // status
    output logic [$clog2(DEPTH):0]     o_LEVEL,
    output logic                       o_OVF_STICKY,
    output logic [CNTW-1:0]            o_ERR_CNT,
    input  logic                       i_CLR_STAT
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = WIDTH + 4;

    localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_MAX    = '1;

    // Storage and pointers. DEPTH is a power of two, so the pointers wrap
    // from DEPTH-1 back to 0 through natural binary overflow.
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    // Statistics
    logic            ovf_sticky_q, ovf_sticky_d;
    logic [CNTW-1:0] err_cnt_q, err_cnt_d;

    // Internal handshake terms
    logic            ready_int;
    logic            valid_int;
    logic            push;
    logic            pop;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   head_entry;

    // Handshake qualification. Reset masks both sides, so the reset cycle ignores push and pop.
    always_comb begin
        ready_int = (!i_RST) && (level_q != FULL_LEVEL);
        valid_int = (!i_RST) && (level_q != '0);
        push      = i_VALID && ready_int;
        pop       = valid_int && i_READY;
        wr_entry  = {i_Y, i_SEL, i_OVF, i_ERR};
    end

    // Storage write: only the slot under the write pointer changes on a push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
        end
    end

    // Pointer and occupancy update. A simultaneous push and pop leaves the level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Statistics update: clear first, then an accepted flagged entry sets or counts on top.
    always_comb begin
        ovf_sticky_d = i_CLR_STAT ? 1'b0 : ovf_sticky_q;
        err_cnt_d    = i_CLR_STAT ? '0   : err_cnt_q;
        if (push && i_OVF) begin
            ovf_sticky_d = 1'b1;
        end
        if (push && i_ERR && (err_cnt_d != CNT_MAX)) begin
            err_cnt_d = err_cnt_d + 1'b1;
        end
    end

    // State registers with synchronous reset; reset also zeroes storage so the head reads 0.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ovf_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ovf_sticky_q <= ovf_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Output decode. The head is read straight from storage (fall-through) and holds while not popped.
    always_comb begin
        head_entry   = mem_q[rd_ptr_q];
        o_READY      = ready_int;
        o_VALID      = valid_int;
        o_Y          = head_entry[EW-1:4];
        o_SEL        = head_entry[3:2];
        o_OVF        = head_entry[1];
        o_ERR        = head_entry[0];
        o_LEVEL      = level_q;
        o_OVF_STICKY = ovf_sticky_q;
        o_ERR_CNT    = err_cnt_q;
    end

endmodule
